// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - goal/frame inputs and score/serve outputs of the match score tracker
interface score_keeper_if #(
  parameter int M_SCORE_W = 4
);
  logic                 frame_tick_i;
  logic                 goal_player_i;
  logic                 goal_enemy_i;
  logic                 start_i;
  logic [M_SCORE_W-1:0] player_score_o;
  logic [M_SCORE_W-1:0] enemy_score_o;
  logic                 serve_o;
  logic                 freeze_o;
  logic                 game_over_o;
  logic                 player_won_o;

  modport master (
    output frame_tick_i, goal_player_i, goal_enemy_i, start_i,
    input  player_score_o, enemy_score_o, serve_o, freeze_o, game_over_o, player_won_o
  );

  modport slave (
    input  frame_tick_i, goal_player_i, goal_enemy_i, start_i,
    output player_score_o, enemy_score_o, serve_o, freeze_o, game_over_o, player_won_o
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - match score tracker: goal counting, serve delay and game-over hold
module score_keeper #(
  parameter int M_SCORE_W    = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input logic            clk_i,
  input logic            rst_ni,
  score_keeper_if.slave  sk
);
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [1:0] {SERVE_WAIT, PLAY, GAME_OVER} state_t;

  state_t               r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [M_SCORE_W-1:0] r_player, r_enemy, w_player_n, w_enemy_n;
  logic [M_SCORE_W-1:0] w_player_inc, w_enemy_inc;
  logic                 r_serve, w_serve_n;
  logic                 r_freeze, w_freeze_n;
  logic                 r_game_over, w_game_over_n;
  logic                 r_player_won, w_player_won_n;

  assign w_player_inc = r_player + M_SCORE_W'(1);
  assign w_enemy_inc  = r_enemy + M_SCORE_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= SERVE_WAIT;
      r_cnt        <= '0;
      r_player     <= '0;
      r_enemy      <= '0;
      r_serve      <= 1'b0;
      r_freeze     <= 1'b1;
      r_game_over  <= 1'b0;
      r_player_won <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_player     <= w_player_n;
      r_enemy      <= w_enemy_n;
      r_serve      <= w_serve_n;
      r_freeze     <= w_freeze_n;
      r_game_over  <= w_game_over_n;
      r_player_won <= w_player_won_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_player_n     = r_player;
    w_enemy_n      = r_enemy;
    w_serve_n      = 1'b0;
    w_freeze_n     = r_freeze;
    w_game_over_n  = r_game_over;
    w_player_won_n = r_player_won;

    // start overrides everything, including a goal in the same cycle
    if (sk.start_i) begin
      w_state_n      = SERVE_WAIT;
      w_cnt_n        = '0;
      w_player_n     = '0;
      w_enemy_n      = '0;
      w_freeze_n     = 1'b1;
      w_game_over_n  = 1'b0;
      w_player_won_n = 1'b0;
    end else begin
      case (r_state)
        SERVE_WAIT: begin
          w_freeze_n = 1'b1;
          if (sk.frame_tick_i) begin
            if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              w_cnt_n    = '0;
              w_serve_n  = 1'b1;
              w_freeze_n = 1'b0;
              w_state_n  = PLAY;
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          w_freeze_n = 1'b0;
          if (sk.goal_player_i && !sk.goal_enemy_i) begin
            w_player_n = w_player_inc;
            w_freeze_n = 1'b1;
            if (w_player_inc == M_SCORE_W'(WIN_SCORE)) begin
              w_state_n      = GAME_OVER;
              w_game_over_n  = 1'b1;
              w_player_won_n = 1'b1;
            end else begin
              w_state_n = SERVE_WAIT;
              w_cnt_n   = '0;
            end
          end else if (sk.goal_enemy_i && !sk.goal_player_i) begin
            w_enemy_n  = w_enemy_inc;
            w_freeze_n = 1'b1;
            if (w_enemy_inc == M_SCORE_W'(WIN_SCORE)) begin
              w_state_n      = GAME_OVER;
              w_game_over_n  = 1'b1;
              w_player_won_n = 1'b0;
            end else begin
              w_state_n = SERVE_WAIT;
              w_cnt_n   = '0;
            end
          end else if (sk.goal_player_i && sk.goal_enemy_i) begin
            // simultaneous goals replay the point without scoring
            w_state_n  = SERVE_WAIT;
            w_cnt_n    = '0;
            w_freeze_n = 1'b1;
          end
        end
        GAME_OVER: begin
          w_freeze_n    = 1'b1;
          w_game_over_n = 1'b1;
        end
        default: begin
          w_state_n = SERVE_WAIT;
        end
      endcase
    end
  end

  assign sk.player_score_o = r_player;
  assign sk.enemy_score_o  = r_enemy;
  assign sk.serve_o        = r_serve;
  assign sk.freeze_o       = r_freeze;
  assign sk.game_over_o    = r_game_over;
  assign sk.player_won_o   = r_player_won;
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper with directed match scenarios
module tb_score_keeper;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  typedef struct {
    int         cyc;
    logic [3:0] ps;
    logic [3:0] es;
    logic       serve;
    logic       freeze;
    logic       go;
    logic       won;
    string      name;
  } ev_t;

  ev_t        q[$];
  logic [3:0] e_ps, e_es;
  logic [10:0] prev;

  score_keeper_if #(.M_SCORE_W(4)) sk ();

  score_keeper #(
    .M_SCORE_W   (4),
    .WIN_SCORE   (9),
    .SERVE_FRAMES(60)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sk    (sk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any serve pulse or change of the other outputs is one DUT event
  always @(posedge clk) begin
    logic [10:0] cur;
    ev_t         e;
    #2;
    if (mon_en) begin
      cur = {sk.player_score_o, sk.enemy_score_o, sk.freeze_o, sk.game_over_o, sk.player_won_o};
      if (sk.serve_o || cur != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc %0d outputs ps=%0d es=%0d serve=%b freeze=%b go=%b won=%b",
                   cyc, sk.player_score_o, sk.enemy_score_o, sk.serve_o, sk.freeze_o,
                   sk.game_over_o, sk.player_won_o);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.ps != sk.player_score_o || e.es != sk.enemy_score_o ||
              e.serve != sk.serve_o || e.freeze != sk.freeze_o || e.go != sk.game_over_o ||
              e.won != sk.player_won_o) begin
            errors++;
            $display("FAIL %s actual cyc=%0d ps=%0d es=%0d serve=%b freeze=%b go=%b won=%b expected cyc=%0d ps=%0d es=%0d serve=%b freeze=%b go=%b won=%b",
                     e.name, cyc, sk.player_score_o, sk.enemy_score_o, sk.serve_o, sk.freeze_o,
                     sk.game_over_o, sk.player_won_o, e.cyc, e.ps, e.es, e.serve, e.freeze,
                     e.go, e.won);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic expect_ev(input string name, input logic [3:0] ps, input logic [3:0] es,
                           input logic serve, input logic freeze, input logic go, input logic won);
    ev_t e;
    e.cyc = cyc + 1;
    e.ps = ps; e.es = es; e.serve = serve; e.freeze = freeze; e.go = go; e.won = won;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input logic t, input logic gp, input logic ge, input logic st);
    @(negedge clk);
    sk.frame_tick_i  = t;
    sk.goal_player_i = gp;
    sk.goal_enemy_i  = ge;
    sk.start_i       = st;
  endtask

  task automatic serve_wait(input string name);
    for (int i = 1; i <= 60; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 60) expect_ev(name, e_ps, e_es, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 30) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goal_player(input string name);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    e_ps = e_ps + 4'd1;
    expect_ev(name, e_ps, e_es, 1'b0, 1'b1, e_ps == 4'd9, e_ps == 4'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goal_enemy(input string name);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    e_es = e_es + 4'd1;
    expect_ev(name, e_ps, e_es, 1'b0, 1'b1, e_es == 4'd9, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
    e_ps = 4'd0; e_es = 4'd0;
    rst_n = 1'b0;
    sk.frame_tick_i = 1'b0; sk.goal_player_i = 1'b0; sk.goal_enemy_i = 1'b0; sk.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("reset_player_score", sk.player_score_o, 0);
    chk("reset_enemy_score", sk.enemy_score_o, 0);
    chk("reset_serve", sk.serve_o, 0);
    chk("reset_freeze", sk.freeze_o, 1);
    chk("reset_game_over", sk.game_over_o, 0);
    chk("reset_player_won", sk.player_won_o, 0);
    prev = {4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    mon_en = 1'b1;

    serve_wait("first_serve");
    goal_player("player_goal_1");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    serve_wait("serve_after_goal");

    drive(1'b0, 1'b1, 1'b1, 1'b0);
    expect_ev("both_goals_replay", e_ps, e_es, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    serve_wait("serve_after_replay");

    for (int i = 0; i < 4; i++) begin
      goal_enemy("enemy_goal");
      serve_wait("serve_enemy_pt");
    end
    for (int i = 0; i < 7; i++) begin
      goal_player("player_goal");
      serve_wait("serve_player_pt");
    end
    goal_player("player_wins_9_4");

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 65; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("game_over_hold_player", sk.player_score_o, 9);
    chk("game_over_hold_enemy", sk.enemy_score_o, 4);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    e_ps = 4'd0; e_es = 4'd0;
    expect_ev("start_clears", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    serve_wait("serve_after_start");

    drive(1'b0, 1'b0, 1'b1, 1'b1);
    expect_ev("start_with_enemy_goal", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    serve_wait("serve_after_start_goal");

    goal_player("p1"); serve_wait("s1");
    goal_enemy("e1");  serve_wait("s2");
    goal_player("p2"); serve_wait("s3");
    goal_enemy("e2");  serve_wait("s4");
    goal_player("p3");
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    e_ps = 4'd0; e_es = 4'd0;
    expect_ev("async_reset_event", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("async_reset_player", sk.player_score_o, 0);
    chk("async_reset_enemy", sk.enemy_score_o, 0);
    chk("async_reset_freeze", sk.freeze_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    serve_wait("serve_after_reset");

    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
